// File: rtl/frame_strobe_seq.sv
// Sequenced frame-strobe generator: accepts (column, frame) writes and drives a
// registered one-hot (or per-column broadcast) strobe with setup/pulse/hold phases.
module frame_strobe_seq #(
    parameter int MaxFramesPerCol  = 20,
    parameter int FrameSelectWidth = 5,
    parameter int NumCols          = 11,
    parameter int FrameIndexWidth  = 5,
    parameter int SetupCycles      = 1,
    parameter int StrobeCycles     = 2,
    parameter int HoldCycles       = 1,
    parameter int BroadcastEn      = 1
) (
    input  logic                                CLK,
    input  logic                                resetn,
    input  logic                                req_valid,
    output logic                                req_ready,
    input  logic [FrameSelectWidth-1:0]         req_col,
    input  logic [FrameIndexWidth-1:0]          req_frame,
    output logic                                busy,
    output logic [NumCols*MaxFramesPerCol-1:0]  FrameStrobe_O,
    output logic                                err,
    input  logic                                err_clr
);

    localparam int NB    = NumCols * MaxFramesPerCol;
    localparam int MaxSP = (SetupCycles > StrobeCycles) ? SetupCycles : StrobeCycles;
    localparam int MaxPh = (MaxSP > HoldCycles) ? MaxSP : HoldCycles;
    localparam int CW    = $clog2(MaxPh + 1);

    // Counter reload values are phase length minus one; the phase ends at zero.
    localparam logic [CW-1:0] SLd = (SetupCycles > 0) ? CW'(SetupCycles - 1) : '0;
    localparam logic [CW-1:0] PLd = CW'(StrobeCycles - 1);
    localparam logic [CW-1:0] HLd = (HoldCycles > 0) ? CW'(HoldCycles - 1) : '0;

    localparam logic [FrameIndexWidth:0]  FLim = (FrameIndexWidth + 1)'(MaxFramesPerCol);
    localparam logic [FrameSelectWidth:0] CLim = (FrameSelectWidth + 1)'(NumCols);

    typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_e;

    state_e                       state_q, state_d;
    logic [CW-1:0]                cnt_q, cnt_d;
    logic [FrameSelectWidth-1:0]  col_q, col_d;
    logic [FrameIndexWidth-1:0]   frame_q, frame_d;
    logic [NB-1:0]                strb_q, strb_d;
    logic                         err_q, err_d;
    logic                         accept, legal;

    function automatic logic [NB-1:0] decode(input logic [FrameSelectWidth-1:0] col,
                                             input logic [FrameIndexWidth-1:0]  frame);
        logic bc;
        decode = '0;
        bc     = (BroadcastEn != 0) && (col == '1);
        for (int c = 0; c < NumCols; c++) begin
            for (int f = 0; f < MaxFramesPerCol; f++) begin
                if ((bc || col == FrameSelectWidth'(c)) && frame == FrameIndexWidth'(f))
                    decode[c*MaxFramesPerCol+f] = 1'b1;
            end
        end
    endfunction

    assign accept = req_valid && (state_q == IDLE);
    assign legal  = ({1'b0, req_frame} < FLim) &&
                    (({1'b0, req_col} < CLim) || ((BroadcastEn != 0) && (req_col == '1)));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        col_d   = col_q;
        frame_d = frame_q;
        strb_d  = '0;
        err_d   = err_q;

        if (err_clr) err_d = 1'b0;
        if (accept) begin
            col_d   = req_col;
            frame_d = req_frame;
            if (!legal) err_d = 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (accept && legal) begin
                    if (SetupCycles > 0) begin
                        state_d = SETUP;
                        cnt_d   = SLd;
                    end else begin
                        // Zero setup: decode straight from the request so the
                        // strobe register is loaded on the accept edge.
                        state_d = STROBE;
                        cnt_d   = PLd;
                        strb_d  = decode(req_col, req_frame);
                    end
                end
            end
            SETUP: begin
                if (cnt_q == '0) begin
                    state_d = STROBE;
                    cnt_d   = PLd;
                    strb_d  = decode(col_q, frame_q);
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            STROBE: begin
                if (cnt_q == '0) begin
                    if (HoldCycles > 0) begin
                        state_d = HOLD;
                        cnt_d   = HLd;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d  = cnt_q - 1'b1;
                    strb_d = strb_q;
                end
            end
            HOLD: begin
                if (cnt_q == '0) state_d = IDLE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            col_q   <= '0;
            frame_q <= '0;
            strb_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            col_q   <= col_d;
            frame_q <= frame_d;
            strb_q  <= strb_d;
            err_q   <= err_d;
        end
    end

    assign req_ready     = (state_q == IDLE);
    assign busy          = (state_q != IDLE);
    assign FrameStrobe_O = strb_q;
    assign err           = err_q;

endmodule

// File: tb/tb_frame_strobe_seq.sv
// Directed bench: instance a uses default timing (1,2,1) with broadcast,
// instance b uses (0,1,0) without broadcast for back-to-back and sweep.
module tb_frame_strobe_seq;

    localparam int M  = 20;
    localparam int NC = 11;
    localparam int NB = NC * M;

    logic          clk, rstn;
    logic          valid_a, ready_a, busy_a, err_a, clr_a;
    logic [4:0]    col_a, fr_a;
    logic [NB-1:0] strb_a;
    logic          valid_b, ready_b, busy_b, err_b, clr_b;
    logic [4:0]    col_b, fr_b;
    logic [NB-1:0] strb_b;

    int n_cmp = 0;
    int n_err = 0;

    frame_strobe_seq u_a (
        .CLK(clk), .resetn(rstn), .req_valid(valid_a), .req_ready(ready_a),
        .req_col(col_a), .req_frame(fr_a), .busy(busy_a), .FrameStrobe_O(strb_a),
        .err(err_a), .err_clr(clr_a)
    );

    frame_strobe_seq #(.SetupCycles(0), .StrobeCycles(1), .HoldCycles(0), .BroadcastEn(0)) u_b (
        .CLK(clk), .resetn(rstn), .req_valid(valid_b), .req_ready(ready_b),
        .req_col(col_b), .req_frame(fr_b), .busy(busy_b), .FrameStrobe_O(strb_b),
        .err(err_b), .err_clr(clr_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [NB-1:0] act, input logic [NB-1:0] exp);
        n_cmp++;
        assert (act === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic act, input logic exp);
        n_cmp++;
        assert (act === exp) else begin
            n_err++;
            $error("FAIL %s: got %0b expected %0b", tag, act, exp);
        end
    endtask

    function automatic logic [NB-1:0] uni(input int c, input int f);
        logic [NB-1:0] r;
        r = '0;
        r[c*M+f] = 1'b1;
        return r;
    endfunction

    function automatic logic [NB-1:0] bcast(input int f);
        logic [NB-1:0] r;
        r = '0;
        for (int c = 0; c < NC; c++) r[c*M+f] = 1'b1;
        return r;
    endfunction

    // One legal request on instance a with default timing: accept edge k,
    // SETUP, two STROBE cycles, HOLD, then IDLE again.
    task automatic req_a(input logic [4:0] c, input logic [4:0] f, input logic [NB-1:0] e);
        valid_a = 1'b1; col_a = c; fr_a = f;
        tick();
        valid_a = 1'b0;
        chk("a_setup_strb", strb_a, '0);
        chk1("a_setup_busy", busy_a, 1'b1);
        chk1("a_setup_ready", ready_a, 1'b0);
        tick();
        chk("a_strobe1", strb_a, e);
        tick();
        chk("a_strobe2", strb_a, e);
        tick();
        chk("a_hold_strb", strb_a, '0);
        chk1("a_hold_busy", busy_a, 1'b1);
        tick();
        chk1("a_idle_ready", ready_a, 1'b1);
        chk1("a_idle_busy", busy_a, 1'b0);
    endtask

    initial begin
        int cs[4];
        int fs[4];
        rstn = 1'b0;
        valid_a = 1'b0; col_a = '0; fr_a = '0; clr_a = 1'b0;
        valid_b = 1'b0; col_b = '0; fr_b = '0; clr_b = 1'b0;
        #3;
        chk("rst_strb", strb_a, '0);
        chk1("rst_busy", busy_a, 1'b0);
        chk1("rst_err", err_a, 1'b0);
        tick(); tick();
        rstn = 1'b1;
        tick();
        chk1("rst_ready", ready_a, 1'b1);

        req_a(5'd3, 5'd7, uni(3, 7));
        req_a(5'd31, 5'd0, bcast(0));
        req_a(5'd10, 5'd19, uni(10, 19));

        // Illegal frame index
        valid_a = 1'b1; col_a = 5'd0; fr_a = 5'd20;
        tick();
        valid_a = 1'b0;
        chk1("ill_frame_err", err_a, 1'b1);
        chk1("ill_frame_ready", ready_a, 1'b1);
        chk1("ill_frame_busy", busy_a, 1'b0);
        chk("ill_frame_strb", strb_a, '0);
        tick();
        chk("ill_frame_strb2", strb_a, '0);
        chk1("ill_err_sticky", err_a, 1'b1);
        clr_a = 1'b1;
        tick();
        clr_a = 1'b0;
        chk1("err_clr", err_a, 1'b0);
        // Illegal column coincident with clear: set wins
        valid_a = 1'b1; clr_a = 1'b1; col_a = 5'd11; fr_a = 5'd0;
        tick();
        valid_a = 1'b0; clr_a = 1'b0;
        chk1("ill_col_setwins", err_a, 1'b1);
        chk("ill_col_strb", strb_a, '0);
        chk1("ill_col_ready", ready_a, 1'b1);

        // Asynchronous reset in the middle of STROBE
        valid_a = 1'b1; col_a = 5'd4; fr_a = 5'd9;
        tick();
        valid_a = 1'b0;
        tick();
        chk("pre_rst_strb", strb_a, uni(4, 9));
        #2;
        rstn = 1'b0;
        #1;
        chk("async_rst_strb", strb_a, '0);
        chk1("async_rst_busy", busy_a, 1'b0);
        chk1("async_rst_err", err_a, 1'b0);
        @(negedge clk);
        rstn = 1'b1;
        tick();
        chk1("post_rst_ready", ready_a, 1'b1);
        chk("post_rst_strb", strb_a, '0);
        tick();
        chk("post_rst_strb2", strb_a, '0);

        // Broadcast code with broadcast disabled is illegal
        valid_b = 1'b1; col_b = 5'd31; fr_b = 5'd0;
        tick();
        valid_b = 1'b0;
        chk1("b_nobc_err", err_b, 1'b1);
        chk("b_nobc_strb", strb_b, '0);
        chk1("b_nobc_ready", ready_b, 1'b1);
        clr_b = 1'b1;
        tick();
        clr_b = 1'b0;
        chk1("b_err_clr", err_b, 1'b0);

        // valid held high: one strobe every 2 cycles with S=0,P=1,H=0
        cs = '{2, 10, 0, 5};
        fs = '{19, 0, 13, 4};
        valid_b = 1'b1;
        for (int i = 0; i < 4; i++) begin
            col_b = 5'(cs[i]); fr_b = 5'(fs[i]);
            tick();
            chk("b2b_strb", strb_b, uni(cs[i], fs[i]));
            chk1("b2b_ready_lo", ready_b, 1'b0);
            tick();
            chk("b2b_gap", strb_b, '0);
            chk1("b2b_ready_hi", ready_b, 1'b1);
        end
        valid_b = 1'b0;

        // Sweep every legal (col, frame) pair
        valid_b = 1'b1;
        for (int c = 0; c < NC; c++) begin
            for (int f = 0; f < M; f++) begin
                col_b = 5'(c); fr_b = 5'(f);
                tick();
                chk("sweep_strb", strb_b, uni(c, f));
                chk1("sweep_onehot", $onehot0(strb_b), 1'b1);
                tick();
                chk("sweep_gap", strb_b, '0);
            end
        end
        valid_b = 1'b0;
        tick();
        chk1("sweep_err", err_b, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
